pmem_arbiter: RTL and testbench



---
 rtl/pmem_arbiter_pkg.sv | 24 ++
 rtl/pmem_arbiter_if.sv | 17 +
 rtl/pmem_arb_fsm.sv | 57 +++++
 rtl/pmem_arbiter.sv | 53 +++++
 tb/tb_pmem_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pmem_arbiter_pkg.sv
// Shared LC-3b physical-memory types: line/address widths and arbiter state encodings.
package lc3b_types;

  typedef logic [15:0]  lc3b_pmem_addr;
  typedef logic [127:0] lc3b_pmem_line;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GRANT_I = 2'b01,
    GRANT_D = 2'b10,
    RELEASE = 2'b11
  } pmem_arb_state_t;

  typedef enum logic {
    PRIO_I = 1'b0,
    PRIO_D = 1'b1
  } pmem_arb_prio_t;

  // One-hot grant vector handed from the FSM to the port muxes.
  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_I    = 2'b01;
  localparam logic [1:0] GNT_D    = 2'b10;

endpackage

// File: rtl/pmem_arbiter_if.sv
// Cache-to-physical-memory line handshake; master drives strobes, slave returns resp/rdata.
interface pmem_arbiter_if;
  import lc3b_types::*;

  logic          read;
  logic          write;
  lc3b_pmem_addr address;
  lc3b_pmem_line wdata;
  logic          resp;
  lc3b_pmem_line rdata;

  modport master (output read, output write, output address, output wdata,
                  input  resp, input  rdata);
  modport slave  (input  read, input  write, input  address, input  wdata,
                  output resp, output rdata);

endinterface

// File: rtl/pmem_arb_fsm.sv
// Ownership FSM for the shared pmem port: state register, round-robin pointer and grant decode.
module pmem_arb_fsm
  import lc3b_types::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_req,
  input  logic       d_req,
  input  logic       pmem_resp,
  output logic [1:0] grant
);

  pmem_arb_state_t state, next_state;
  pmem_arb_prio_t  prio, next_prio;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      prio  <= PRIO_D;
    end else begin
      state <= next_state;
      prio  <= next_prio;
    end
  end

  always_comb begin
    next_state = state;
    next_prio  = prio;
    case (state)
      IDLE: begin
        // The winner hands priority to the other side for the next conflict.
        if (i_req && (!d_req || prio == PRIO_I)) begin
          next_state = GRANT_I;
          next_prio  = PRIO_D;
        end else if (d_req) begin
          next_state = GRANT_D;
          next_prio  = PRIO_I;
        end
      end
      GRANT_I, GRANT_D: begin
        if (pmem_resp) next_state = RELEASE;
      end
      RELEASE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    grant = GNT_NONE;
    case (state)
      GRANT_I: grant = GNT_I;
      GRANT_D: grant = GNT_D;
      default: grant = GNT_NONE;
    endcase
  end

endmodule

// File: rtl/pmem_arbiter.sv
// Shares one pmem port between I-cache and D-cache: grant-driven muxes and response steering.
module pmem_arbiter
  import lc3b_types::*;
(
  input  logic           clk,
  input  logic           reset,
  pmem_arbiter_if.slave  i_bus,
  pmem_arbiter_if.slave  d_bus,
  pmem_arbiter_if.master mem
);

  logic [1:0] grant;
  logic       unused_i_bus;

  // The I-cache never writes back; its write side of the bus is ignored.
  assign unused_i_bus = ^{i_bus.write, i_bus.wdata};

  pmem_arb_fsm u_fsm (
    .clk       (clk),
    .reset     (reset),
    .i_req     (i_bus.read),
    .d_req     (d_bus.read | d_bus.write),
    .pmem_resp (mem.resp),
    .grant     (grant)
  );

  always_comb begin
    mem.read    = 1'b0;
    mem.write   = 1'b0;
    mem.address = '0;
    mem.wdata   = '0;
    case (grant)
      GNT_I: begin
        mem.read    = i_bus.read;
        mem.address = i_bus.address;
      end
      GNT_D: begin
        mem.read    = d_bus.read;
        mem.write   = d_bus.write;
        mem.address = d_bus.address;
        mem.wdata   = d_bus.wdata;
      end
      default: ;
    endcase
  end

  // Read data fans out unqualified; each cache trusts it only under its own resp.
  assign i_bus.resp  = mem.resp & (grant == GNT_I);
  assign d_bus.resp  = mem.resp & (grant == GNT_D);
  assign i_bus.rdata = mem.rdata;
  assign d_bus.rdata = mem.rdata;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Bench for pmem_arbiter: directed vector table, traffic sequences and random stimulus vs a reference model.
module tb_pmem_arbiter;
  import lc3b_types::*;

  logic clk;
  logic reset;

  pmem_arbiter_if i_bus ();
  pmem_arbiter_if d_bus ();
  pmem_arbiter_if mem ();

  pmem_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .i_bus (i_bus),
    .d_bus (d_bus),
    .mem   (mem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  typedef struct {
    logic          rst;
    logic          ir;
    lc3b_pmem_addr ia;
    logic          dr;
    logic          dw;
    lc3b_pmem_addr da;
    lc3b_pmem_line dwd;
    logic          resp;
    lc3b_pmem_line rdat;
    logic          erd;
    logic          ewr;
    lc3b_pmem_addr ead;
    lc3b_pmem_line ewd;
    logic          eir;
    logic          edr;
  } vec_t;

  typedef struct {
    logic          is_d;
    logic          wr;
    lc3b_pmem_addr addr;
  } txn_t;

  vec_t          tbl[22];
  txn_t          log_q[$];
  lc3b_pmem_addr iq[$];
  txn_t          dq[$];

  // Reference model: who owns the port, whether we sit in the post-response gap,
  // and which side won the most recent arbitration (the other wins the next tie).
  int m_owner;
  bit m_gap;
  int m_last_winner;

  function automatic vec_t v(input logic rst, input logic ir, input logic [15:0] ia,
                             input logic dr, input logic dw, input logic [15:0] da,
                             input logic [7:0] dwd, input logic resp, input logic [7:0] rdat,
                             input logic erd, input logic ewr, input logic [15:0] ead,
                             input logic [7:0] ewd, input logic eir, input logic edr);
    vec_t r;
    r.rst = rst;  r.ir = ir;  r.ia = ia;  r.dr = dr;  r.dw = dw;  r.da = da;
    r.dwd = {120'd0, dwd};  r.resp = resp;  r.rdat = {120'd0, rdat};
    r.erd = erd;  r.ewr = ewr;  r.ead = ead;  r.ewd = {120'd0, ewd};
    r.eir = eir;  r.edr = edr;
    return r;
  endfunction

  task automatic chk(input string name, input logic e_rd, input logic e_wr,
                     input lc3b_pmem_addr e_ad, input lc3b_pmem_line e_wd,
                     input logic e_ir, input logic e_dr, input lc3b_pmem_line e_rdat);
    vectors++;
    if (mem.read !== e_rd || mem.write !== e_wr || mem.address !== e_ad ||
        mem.wdata !== e_wd || i_bus.resp !== e_ir || d_bus.resp !== e_dr ||
        i_bus.rdata !== e_rdat || d_bus.rdata !== e_rdat) begin
      miscompares++;
      $display("FAIL %s @%0t: got rd=%b wr=%b addr=%h wdata=%h iresp=%b dresp=%b irdata=%h drdata=%h, want rd=%b wr=%b addr=%h wdata=%h iresp=%b dresp=%b rdata=%h",
               name, $time, mem.read, mem.write, mem.address, mem.wdata, i_bus.resp,
               d_bus.resp, i_bus.rdata, d_bus.rdata, e_rd, e_wr, e_ad, e_wd, e_ir, e_dr, e_rdat);
    end
  endtask

  task automatic model_check(input string name);
    logic          e_rd, e_wr, e_ir, e_dr;
    lc3b_pmem_addr e_ad;
    lc3b_pmem_line e_wd;
    e_rd = 1'b0; e_wr = 1'b0; e_ir = 1'b0; e_dr = 1'b0; e_ad = '0; e_wd = '0;
    if (m_owner == 1) begin
      e_rd = i_bus.read;  e_ad = i_bus.address;  e_ir = mem.resp;
    end else if (m_owner == 2) begin
      e_rd = d_bus.read;  e_wr = d_bus.write;  e_ad = d_bus.address;
      e_wd = d_bus.wdata; e_dr = mem.resp;
    end
    chk(name, e_rd, e_wr, e_ad, e_wd, e_ir, e_dr, mem.rdata);
  endtask

  // Advance the model by one clock using the inputs the DUT is about to sample.
  task automatic model_step();
    bit want_i, want_d;
    want_i = i_bus.read;
    want_d = d_bus.read | d_bus.write;
    if (reset) begin
      m_owner = 0;  m_gap = 1'b0;  m_last_winner = 1;
    end else if (m_owner != 0) begin
      if (mem.resp) begin
        m_owner = 0;  m_gap = 1'b1;
      end
    end else if (m_gap) begin
      m_gap = 1'b0;
    end else begin
      if (want_i && want_d) m_owner = (m_last_winner == 1) ? 2 : 1;
      else if (want_i)      m_owner = 1;
      else if (want_d)      m_owner = 2;
      if (m_owner != 0) m_last_winner = m_owner;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_inputs();
    i_bus.read = 1'b0;  i_bus.write = 1'b0;  i_bus.address = '0;  i_bus.wdata = '0;
    d_bus.read = 1'b0;  d_bus.write = 1'b0;  d_bus.address = '0;  d_bus.wdata = '0;
    mem.resp = 1'b0;    mem.rdata = '0;
  endtask

  task automatic do_reset();
    zero_inputs();
    reset = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) begin
      #2 model_check("reset_hold");
      tick();
    end
    reset = 1'b0;
  endtask

  // Caches hold a request until their resp, drop it for one cycle, then present the next.
  task automatic run_traffic(input int lat, input int budget);
    int mcnt;
    int cyc;
    bit i_gap, d_gap;
    mcnt = 0;  cyc = 0;  i_gap = 1'b0;  d_gap = 1'b0;
    log_q.delete();
    while ((iq.size() > 0 || dq.size() > 0) && cyc < budget) begin
      i_bus.read    = (iq.size() > 0) && !i_gap;
      i_bus.address = (iq.size() > 0) ? iq[0] : '0;
      i_gap = 1'b0;
      if (dq.size() > 0 && !d_gap) begin
        d_bus.read = !dq[0].wr;  d_bus.write = dq[0].wr;  d_bus.address = dq[0].addr;
      end else begin
        d_bus.read = 1'b0;  d_bus.write = 1'b0;  d_bus.address = '0;
      end
      d_gap = 1'b0;
      d_bus.wdata = {$urandom, $urandom, $urandom, $urandom};
      mem.rdata   = {$urandom, $urandom, $urandom, $urandom};
      mem.resp    = 1'b0;
      #1;
      if (mem.read || mem.write) begin
        mcnt++;
        mem.resp = (mcnt >= lat);
      end
      #1;
      model_check("traffic");
      if (i_bus.resp || d_bus.resp) begin
        log_q.push_back('{d_bus.resp, mem.write, mem.address});
        mcnt = 0;
      end
      if (i_bus.resp && iq.size() > 0) begin
        void'(iq.pop_front());
        i_gap = 1'b1;
      end
      if (d_bus.resp && dq.size() > 0) begin
        void'(dq.pop_front());
        d_gap = 1'b1;
      end
      tick();
      cyc++;
    end
    if (cyc >= budget) begin
      vectors++;
      miscompares++;
      $display("FAIL traffic_timeout: %0d cycles used, required completion within %0d", cyc, budget);
    end
    zero_inputs();
  endtask

  task automatic check_order(input string name, input int idx, input txn_t e);
    vectors++;
    if (idx >= log_q.size()) begin
      miscompares++;
      $display("FAIL %s[%0d]: got no transaction, want is_d=%b wr=%b addr=%h",
               name, idx, e.is_d, e.wr, e.addr);
    end else if (log_q[idx].is_d !== e.is_d || log_q[idx].wr !== e.wr ||
                 log_q[idx].addr !== e.addr) begin
      miscompares++;
      $display("FAIL %s[%0d]: got is_d=%b wr=%b addr=%h, want is_d=%b wr=%b addr=%h",
               name, idx, log_q[idx].is_d, log_q[idx].wr, log_q[idx].addr,
               e.is_d, e.wr, e.addr);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t exp_c[6];
    txn_t exp_w[3];
    vectors = 0;
    miscompares = 0;
    m_owner = 0;  m_gap = 1'b0;  m_last_winner = 1;

    //            rst ir ia       dr dw da       dwd   rsp rdat  erd ewr ead      ewd   eir edr
    tbl[0]  = v(0, 0, 16'h0000, 0, 0, 16'h0000, 8'h00, 1, 8'hA1, 0, 0, 16'h0000, 8'h00, 0, 0);
    tbl[1]  = v(0, 0, 16'h0000, 0, 0, 16'h0000, 8'h00, 0, 8'hA2, 0, 0, 16'h0000, 8'h00, 0, 0);
    tbl[2]  = v(0, 1, 16'h1230, 0, 0, 16'h0000, 8'h00, 0, 8'hA3, 0, 0, 16'h0000, 8'h00, 0, 0);
    tbl[3]  = v(0, 1, 16'h1230, 0, 0, 16'h0000, 8'h00, 0, 8'hA4, 1, 0, 16'h1230, 8'h00, 0, 0);
    tbl[4]  = v(0, 1, 16'h1230, 0, 0, 16'h0000, 8'h00, 0, 8'hA4, 1, 0, 16'h1230, 8'h00, 0, 0);
    tbl[5]  = v(0, 1, 16'h1230, 0, 0, 16'h0000, 8'h00, 0, 8'hA4, 1, 0, 16'h1230, 8'h00, 0, 0);
    tbl[6]  = v(0, 1, 16'h1230, 0, 0, 16'h0000, 8'h00, 1, 8'hAA, 1, 0, 16'h1230, 8'h00, 1, 0);
    tbl[7]  = v(0, 0, 16'h0000, 0, 0, 16'h0000, 8'h00, 0, 8'hA5, 0, 0, 16'h0000, 8'h00, 0, 0);
    tbl[8]  = v(0, 1, 16'h0040, 0, 1, 16'h0080, 8'h55, 0, 8'hA6, 0, 0, 16'h0000, 8'h00, 0, 0);
    tbl[9]  = v(0, 1, 16'h0040, 0, 1, 16'h0080, 8'h55, 0, 8'hA7, 0, 1, 16'h0080, 8'h55, 0, 0);
    tbl[10] = v(0, 1, 16'h0040, 0, 1, 16'h0080, 8'h55, 1, 8'hB1, 0, 1, 16'h0080, 8'h55, 0, 1);
    tbl[11] = v(0, 1, 16'h0040, 0, 0, 16'h0000, 8'h00, 0, 8'hB2, 0, 0, 16'h0000, 8'h00, 0, 0);
    tbl[12] = v(0, 1, 16'h0040, 0, 0, 16'h0000, 8'h00, 0, 8'hB3, 0, 0, 16'h0000, 8'h00, 0, 0);
    tbl[13] = v(0, 1, 16'h0040, 0, 0, 16'h0000, 8'h00, 0, 8'hB4, 1, 0, 16'h0040, 8'h00, 0, 0);
    tbl[14] = v(0, 0, 16'h0040, 0, 0, 16'h0000, 8'h00, 0, 8'hB5, 0, 0, 16'h0040, 8'h00, 0, 0);
    tbl[15] = v(0, 0, 16'h0040, 0, 0, 16'h0000, 8'h00, 1, 8'hB6, 0, 0, 16'h0040, 8'h00, 1, 0);
    tbl[16] = v(0, 0, 16'h0000, 1, 1, 16'h0300, 8'h77, 0, 8'hC1, 0, 0, 16'h0000, 8'h00, 0, 0);
    tbl[17] = v(0, 0, 16'h0000, 1, 1, 16'h0300, 8'h77, 0, 8'hC2, 0, 0, 16'h0000, 8'h00, 0, 0);
    tbl[18] = v(0, 0, 16'h0000, 1, 1, 16'h0300, 8'h77, 0, 8'hC3, 1, 1, 16'h0300, 8'h77, 0, 0);
    tbl[19] = v(1, 0, 16'h0000, 1, 1, 16'h0300, 8'h77, 0, 8'hC4, 1, 1, 16'h0300, 8'h77, 0, 0);
    tbl[20] = v(0, 1, 16'h0500, 1, 1, 16'h0300, 8'h77, 0, 8'hC5, 0, 0, 16'h0000, 8'h00, 0, 0);
    tbl[21] = v(0, 1, 16'h0500, 1, 1, 16'h0300, 8'h77, 0, 8'hC6, 1, 1, 16'h0300, 8'h77, 0, 0);

    do_reset();
    for (int k = 0; k < 22; k++) begin
      reset         = tbl[k].rst;
      i_bus.read    = tbl[k].ir;   i_bus.address = tbl[k].ia;
      d_bus.read    = tbl[k].dr;   d_bus.write   = tbl[k].dw;
      d_bus.address = tbl[k].da;   d_bus.wdata   = tbl[k].dwd;
      mem.resp      = tbl[k].resp; mem.rdata     = tbl[k].rdat;
      #2;
      chk($sformatf("table_row%0d", k), tbl[k].erd, tbl[k].ewr, tbl[k].ead, tbl[k].ewd,
          tbl[k].eir, tbl[k].edr, tbl[k].rdat);
      tick();
    end

    // Continuous contention: three reads from each cache, grants must alternate D first.
    do_reset();
    iq = '{16'h1000, 16'h1010, 16'h1020};
    dq = '{'{1'b0, 1'b0, 16'h2000}, '{1'b0, 1'b0, 16'h2010}, '{1'b0, 1'b0, 16'h2020}};
    run_traffic(2, 200);
    exp_c[0] = '{1'b1, 1'b0, 16'h2000};
    exp_c[1] = '{1'b0, 1'b0, 16'h1000};
    exp_c[2] = '{1'b1, 1'b0, 16'h2010};
    exp_c[3] = '{1'b0, 1'b0, 16'h1010};
    exp_c[4] = '{1'b1, 1'b0, 16'h2020};
    exp_c[5] = '{1'b0, 1'b0, 16'h1020};
    for (int k = 0; k < 6; k++) check_order("contention_order", k, exp_c[k]);

    // Write-back then refill from D with an I read pending: I slots in between.
    do_reset();
    iq = '{16'h0600};
    dq = '{'{1'b0, 1'b1, 16'h0100}, '{1'b0, 1'b0, 16'h0200}};
    run_traffic(3, 200);
    exp_w[0] = '{1'b1, 1'b1, 16'h0100};
    exp_w[1] = '{1'b0, 1'b0, 16'h0600};
    exp_w[2] = '{1'b1, 1'b0, 16'h0200};
    for (int k = 0; k < 3; k++) check_order("writeback_order", k, exp_w[k]);

    do_reset();
    for (int k = 0; k < 600; k++) begin
      reset         = ($urandom_range(0, 39) == 0);
      i_bus.read    = $urandom_range(0, 1) == 1;
      i_bus.address = lc3b_pmem_addr'($urandom);
      d_bus.read    = $urandom_range(0, 1) == 1;
      d_bus.write   = $urandom_range(0, 3) == 0;
      d_bus.address = lc3b_pmem_addr'($urandom);
      d_bus.wdata   = {$urandom, $urandom, $urandom, $urandom};
      mem.resp      = $urandom_range(0, 2) == 0;
      mem.rdata     = {$urandom, $urandom, $urandom, $urandom};
      #2 model_check("random");
      tick();
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
